// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Round-robin arbiter that shares the single register-file write port among
//   NREQ writeback sources, plus a one-bit-per-register busy scoreboard that
//   decode queries to stall reads of registers with an uncommitted producer.
//   Optional feature macro: WB_BYPASS_EN (forward the write in its commit
//   cycle so decode need not stall for it).
//
// Handshake: requester i transfers its result on a rising edge where
//   req_valid[i] && req_ready[i]. req_ready is a combinational one-hot grant
//   derived from req_valid and the round-robin pointer; a requester must hold
//   req_valid/req_rd/req_data stable until it sees the transfer. The write
//   port never back-pressures, so at most one transfer happens per cycle and
//   it always succeeds whenever any requester is valid.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               w_en,
  output logic [AW-1:0]      rd,
  output logic [XLEN-1:0]    wr_data,
  input  logic               sb_set,
  input  logic [AW-1:0]      sb_set_rd,
  input  logic [AW-1:0]      rs1,
  input  logic [AW-1:0]      rs2,
  output logic               stall,
  output logic               fwd_hit1,
  output logic               fwd_hit2,
  output logic [XLEN-1:0]    fwd_data1,
  output logic [XLEN-1:0]    fwd_data2
);

  localparam int NREG = 1 << AW;
  localparam int PW   = $clog2(NREQ);
  localparam int CW   = PW + 1;
  localparam logic [CW-1:0] NREQ_W = CW'(NREQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic [CW-1:0]   cand;
  logic [PW-1:0]   nxt_ptr;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy;

  // Round-robin search from rr_ptr upward (mod NREQ); first valid wins.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!grant_any && req_valid[cand[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign sel_rd   = req_rd[grant_idx*AW +: AW];
  assign sel_data = req_data[grant_idx*XLEN +: XLEN];
  assign nxt_ptr  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  // Register the granted write; x0 writes consume the grant but never enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en    <= 1'b0;
      rd      <= '0;
      wr_data <= '0;
      rr_ptr  <= '0;
    end else if (grant_any) begin
      w_en    <= (sel_rd != '0);
      rd      <= sel_rd;
      wr_data <= sel_data;
      rr_ptr  <= nxt_ptr;
    end else begin
      w_en    <= 1'b0;
    end
  end

  // Busy scoreboard: commit clears, issue sets; the set is written last so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (w_en) busy[rd] <= 1'b0;
      if (sb_set && (sb_set_rd != '0)) busy[sb_set_rd] <= 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the value being committed this cycle to a matching source read.
  always_comb begin
    fwd_hit1  = w_en && (rd == rs1) && (rs1 != '0);
    fwd_hit2  = w_en && (rd == rs2) && (rs2 != '0);
    fwd_data1 = fwd_hit1 ? wr_data : '0;
    fwd_data2 = fwd_hit2 ? wr_data : '0;
  end
`else
  // No forward path: decode waits for the register file to return the value.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
  end
`endif

  // Stall while a nonzero source register is busy and not being forwarded.
  always_comb begin
    stall = ((rs1 != '0) && busy[rs1] && !fwd_hit1) ||
            ((rs2 != '0) && busy[rs2] && !fwd_hit2);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed vectors with hand-computed expectations for regfile_wb_arbiter
//   (NREQ=3, XLEN=32, AW=5). Expectations for the forward path follow the
//   WB_BYPASS_EN macro.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               w_en;
  logic [AW-1:0]      rd;
  logic [XLEN-1:0]    wr_data;
  logic               sb_set;
  logic [AW-1:0]      sb_set_rd;
  logic [AW-1:0]      rs1;
  logic [AW-1:0]      rs2;
  logic               stall;
  logic               fwd_hit1;
  logic               fwd_hit2;
  logic [XLEN-1:0]    fwd_data1;
  logic [XLEN-1:0]    fwd_data2;

  int n_vec;
  int n_err;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_rd;
  logic [NREQ-1:0] exp_gnt [4];
  logic [XLEN-1:0] exp_dat [4];

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready),
    .w_en(w_en), .rd(rd), .wr_data(wr_data),
    .sb_set(sb_set), .sb_set_rd(sb_set_rd),
    .rs1(rs1), .rs2(rs2),
    .stall(stall),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [NREQ-1:0] v,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2,
                         input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                         input logic [XLEN-1:0] d2);
    req_valid = v;
    req_rd    = {r2, r1, r0};
    req_data  = {d2, d1, d0};
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100; exp_gnt[3] = 3'b001;
    exp_dat[0] = 32'h11; exp_dat[1] = 32'h22; exp_dat[2] = 32'h33; exp_dat[3] = 32'h11;

    rst_n = 1'b0;
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    sb_set = 1'b0; sb_set_rd = '0; rs1 = '0; rs2 = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    rs1 = 5'd5; settle();
    chk("rst_w_en", 64'(w_en), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    rs1 = '0;

    // All three valid for four cycles: grants 0,1,2,0
    set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("rr_ready", 64'(req_ready), 64'(exp_gnt[c]));
      exp_q.push_back(AW'(c % 3 + 1));
      tick();
      exp_rd = exp_q.pop_front();
      chk("rr_w_en", 64'(w_en), 64'd1);
      chk("rr_rd", 64'(rd), 64'(exp_rd));
      chk("rr_wr_data", 64'(wr_data), 64'(exp_dat[c]));
    end

    // No request: w_en drops, rd/wr_data hold
    set_req(3'b000, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
    settle();
    chk("idle_ready", 64'(req_ready), 64'd0);
    tick();
    chk("idle_w_en", 64'(w_en), 64'd0);
    chk("idle_rd_hold", 64'(rd), 64'd1);
    chk("idle_data_hold", 64'(wr_data), 64'h11);

    // x0 request from req1 (rr_ptr=1): granted, no write, rd/data loaded
    set_req(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h55, 32'h0);
    settle();
    chk("x0_ready", 64'(req_ready), 64'b010);
    tick();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("x0_w_en", 64'(w_en), 64'd0);
    chk("x0_rd", 64'(rd), 64'd0);
    chk("x0_wr_data", 64'(wr_data), 64'h55);
    // rr_ptr must now be 2: all-valid picks requester 2 (no edge taken)
    set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
    settle();
    chk("x0_ptr2", 64'(req_ready), 64'b100);
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    settle();

    // Scoreboard: busy r7, stall until commit
    sb_set = 1'b1; sb_set_rd = 5'd7;
    tick();
    sb_set = 1'b0;
    rs1 = 5'd7; settle();
    chk("sb7_stall_a", 64'(stall), 64'd1);
    tick();
    chk("sb7_stall_b", 64'(stall), 64'd1);
    set_req(3'b001, 5'd7, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    settle();
    chk("sb7_ready", 64'(req_ready), 64'b001);
    tick();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    settle();
    chk("sb7_w_en", 64'(w_en), 64'd1);
    chk("sb7_rd", 64'(rd), 64'd7);
`ifdef WB_BYPASS_EN
    chk("sb7_commit_stall", 64'(stall), 64'd0);
    chk("sb7_fwd_hit1", 64'(fwd_hit1), 64'd1);
    chk("sb7_fwd_data1", 64'(fwd_data1), 64'hDEADBEEF);
`else
    chk("sb7_commit_stall", 64'(stall), 64'd1);
    chk("sb7_fwd_hit1", 64'(fwd_hit1), 64'd0);
    chk("sb7_fwd_data1", 64'(fwd_data1), 64'd0);
`endif
    chk("sb7_fwd_hit2", 64'(fwd_hit2), 64'd0);
    tick();
    chk("sb7_after_stall", 64'(stall), 64'd0);
    chk("sb7_after_w_en", 64'(w_en), 64'd0);
    rs1 = '0;

    // Set and clear of r9 on the same edge: set wins (rr_ptr=1 now)
    sb_set = 1'b1; sb_set_rd = 5'd9;
    tick();
    sb_set = 1'b0;
    set_req(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h99, 32'h0);
    settle();
    chk("sb9_ready", 64'(req_ready), 64'b010);
    tick();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("sb9_w_en", 64'(w_en), 64'd1);
    chk("sb9_rd", 64'(rd), 64'd9);
    sb_set = 1'b1; sb_set_rd = 5'd9;
    tick();
    sb_set = 1'b0;
    rs2 = 5'd9; settle();
    chk("sb9_w_en_off", 64'(w_en), 64'd0);
    chk("sb9_set_wins", 64'(stall), 64'd1);
    rs2 = '0;

    // x0 sources never stall, sb_set on x0 ignored
    sb_set = 1'b1; sb_set_rd = 5'd0;
    tick();
    sb_set = 1'b0;
    rs1 = '0; rs2 = '0; settle();
    chk("x0_stall", 64'(stall), 64'd0);

    // Reset mid-write with busy r5 (and r9) set
    sb_set = 1'b1; sb_set_rd = 5'd5;
    tick();
    sb_set = 1'b0;
    rs1 = 5'd5; settle();
    chk("mid_stall_pre", 64'(stall), 64'd1);
    set_req(3'b001, 5'd5, 5'd0, 5'd0, 32'hA5A5A5A5, 32'h0, 32'h0);
    tick();
    chk("mid_w_en_pre", 64'(w_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_w_en_rst", 64'(w_en), 64'd0);
    chk("mid_stall_rst", 64'(stall), 64'd0);
    chk("mid_rd_rst", 64'(rd), 64'd0);
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    rs2 = 5'd9; settle();
    chk("post_w_en", 64'(w_en), 64'd0);
    chk("post_wr_data", 64'(wr_data), 64'd0);
    chk("post_stall", 64'(stall), 64'd0);
    // rr_ptr back to 0 after reset
    set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
    settle();
    chk("post_ptr0", 64'(req_ready), 64'b001);
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
